uart_rx_byte: RTL and testbench

//   UART receiver, 8N1, LSB first. Deserialises the rxIN line into a byte and

---
 rtl/uart_rx_byte_pkg.sv | 24 ++
 rtl/uart_rx_byte_sync_2ff.sv | 28 ++
 rtl/uart_rx_byte.sv | 193 +++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_byte_pkg.sv
// Shared definitions for the UART receive path: state encoding, default bit
// timing and the counter-width helper. The future TX block imports this too.
package uart_rx_byte_pkg;

    // 50 MHz system clock, 115200 baud
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

    // 8N1 framing: eight data bits, no parity, one stop bit
    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    // Width of a counter that must reach clks-1; never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_byte_sync_2ff.sv
// Two-flop synchroniser for the asynchronous serial line. Both flops reset to
// 1 so a reset never looks like a start bit to the receiver.
module uart_rx_byte_sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the raw line through two flops to resolve metastability
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            // NOTE: non-blocking so each flop takes the other's pre-edge value;
            // blocking here would collapse the chain into a single flop.
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver, LSB first. Centres on the start bit, samples each data
// bit mid-cell, checks the stop bit and hands the byte to a downstream holding
// register through a level done/ack handshake. Returns to IDLE at mid-stop so a
// back-to-back start edge is never missed. CLKS_PER_BIT must be at least 4.
module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clkIN,
    input  logic                 nResetIN,
    input  logic                 rxIN,
    input  logic                 ackIN,
    output logic [DATA_BITS-1:0] dataOUT,
    output logic                 doneOUT,
    output logic                 frameErrOUT,
    output logic                 overrunOUT,
    output logic                 busyOUT
);

    // Start-bit centring delay is derived, never set independently
    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W    = cnt_width(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [2:0]       BIT_IDX_LAST  = 3'(DATA_BITS - 1);

    // Synchronised serial line; every decision below looks only at this
    logic rx_s;

    // Frame FSM state and datapath
    rx_state_e            state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 frame_err_q;
    logic                 busy_q;

    // Handshake registers towards the byte-holding register
    logic [DATA_BITS-1:0] data_q;
    logic [DATA_BITS-1:0] data_d;
    logic                 done_q;
    logic                 done_d;
    logic                 overrun_q;
    logic                 overrun_d;

    logic bit_end;
    logic good_stop;

    uart_rx_byte_sync_2ff u_sync (
        .clk_i  (clkIN),
        .rst_ni (nResetIN),
        .d_i    (rxIN),
        .q_o    (rx_s)
    );

    // A full bit cell has elapsed in DATA or STOP
    assign bit_end   = (cnt_q == CNT_BIT_LAST);
    // Stop bit sampled high: the shifted byte is complete and well framed
    assign good_stop = (state_q == ST_STOP) && bit_end && rx_s;

    // Frame FSM: start centring, data sampling, stop check and break recovery
    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // Frame error is a single-cycle pulse unless re-asserted below
            frame_err_q <= 1'b0;

            unique case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s) begin
                        state_q <= ST_START;
                        busy_q  <= 1'b1;
                    end
                end

                ST_START: begin
                    if (cnt_q == CNT_HALF_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            // Line went back high before mid-start: a glitch
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= ST_DATA;
                            bit_idx_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                ST_DATA: begin
                    if (bit_end) begin
                        cnt_q              <= '0;
                        shift_q[bit_idx_q] <= rx_s;
                        // Index stops at the last bit instead of wrapping
                        if (bit_idx_q == BIT_IDX_LAST) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                ST_STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            // Leave at mid-stop so the next start edge is caught
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end

                ST_BREAK: begin
                    // A held-low line must not be mistaken for a new start bit
                    cnt_q <= '0;
                    if (rx_s) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Next-state for the done/overrun handshake; a new byte beats an ack
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        data_d    = data_q;
        done_d    = done_q;
        overrun_d = overrun_q;

        if (ackIN) begin
            done_d    = 1'b0;
            overrun_d = 1'b0;
        end

        if (good_stop) begin
            data_d = shift_q;
            done_d = 1'b1;
            // Only an unacknowledged previous byte counts as lost
            if (done_q && !ackIN) begin
                overrun_d = 1'b1;
            end
        end
    end

    // Handshake registers
    always_ff @(posedge clkIN or negedge nResetIN) begin
        if (!nResetIN) begin
            data_q    <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    assign dataOUT     = data_q;
    assign doneOUT     = done_q;
    assign frameErrOUT = frame_err_q;
    assign overrunOUT  = overrun_q;
    assign busyOUT     = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 8 clocks per bit. All stimulus and
// sampling happen on the falling clock edge; a per-cycle monitor records
// doneOUT rises, frame-error pulses and busy activity for later checks.
module tb_uart_rx_byte;

    localparam int unsigned CPB = 8;
    localparam int unsigned HB  = CPB / 2;
    localparam int unsigned LAT = 2 + HB + 9 * CPB;   // 78

    logic       clkIN = 1'b0;
    logic       nResetIN;
    logic       rxIN;
    logic       ackIN;
    logic [7:0] dataOUT;
    logic       doneOUT;
    logic       frameErrOUT;
    logic       overrunOUT;
    logic       busyOUT;

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
        .clkIN       (clkIN),
        .nResetIN    (nResetIN),
        .rxIN        (rxIN),
        .ackIN       (ackIN),
        .dataOUT     (dataOUT),
        .doneOUT     (doneOUT),
        .frameErrOUT (frameErrOUT),
        .overrunOUT  (overrunOUT),
        .busyOUT     (busyOUT)
    );

    always #5 clkIN = ~clkIN;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         rise_cnt;
    int         rise_cyc;
    int         ferr_cnt;
    bit         busy_seen;
    bit         ack_auto = 1'b0;
    logic       done_prev = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] last_got;
    int         t0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clock: wait for the falling edge, then observe and optionally ack
    task automatic step();
        @(negedge clkIN);
        cyc++;
        if (doneOUT && !done_prev) begin
            rise_cnt++;
            rise_cyc = cyc;
            got_q.push_back(dataOUT);
            last_got = dataOUT;
        end
        done_prev = doneOUT;
        if (frameErrOUT) ferr_cnt++;
        if (busyOUT) busy_seen = 1'b1;
        if (ack_auto) ackIN = doneOUT;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_mon();
        rise_cnt  = 0;
        rise_cyc  = -1;
        ferr_cnt  = 0;
        busy_seen = 1'b0;
        last_got  = 8'hxx;
        got_q.delete();
    endtask

    task automatic send_bit(input logic b);
        rxIN = b;
        steps(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int start_cyc);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
    endtask

    initial begin
        nResetIN = 1'b0;
        rxIN     = 1'b1;
        ackIN    = 1'b0;
        clear_mon();

        // Reset state
        steps(3);
        check("rst_data",    32'(dataOUT),     32'h00);
        check("rst_done",    32'(doneOUT),     32'h0);
        check("rst_ferr",    32'(frameErrOUT), 32'h0);
        check("rst_overrun", 32'(overrunOUT),  32'h0);
        check("rst_busy",    32'(busyOUT),     32'h0);
        nResetIN = 1'b1;
        steps(4);

        // Single frame 0x55, ack follows done by one cycle; exact latency
        ack_auto = 1'b1;
        clear_mon();
        send_frame(8'h55, 1'b1, t0);
        steps(4);
        check("f55_rises",   32'(rise_cnt), 32'd1);
        check("f55_data",    32'(last_got), 32'h55);
        check("f55_latency", 32'(rise_cyc - t0 - 1), 32'(LAT));
        check("f55_cleared", 32'(doneOUT), 32'h0);
        check("f55_ferr",    32'(ferr_cnt), 32'd0);

        // Back-to-back 0xA5, 0x3C with no idle gap
        clear_mon();
        send_frame(8'hA5, 1'b1, t0);
        send_frame(8'h3C, 1'b1, t0);
        steps(4);
        check("b2b_count",   32'(got_q.size()), 32'd2);
        check("b2b_first",   32'(got_q[0]), 32'hA5);
        check("b2b_second",  32'(got_q[1]), 32'h3C);
        check("b2b_ferr",    32'(ferr_cnt), 32'd0);
        check("b2b_overrun", 32'(overrunOUT), 32'h0);
        check("b2b_busy",    32'(busyOUT), 32'h0);

        // Two-cycle low glitch on the idle line
        clear_mon();
        rxIN = 1'b0;
        steps(2);
        rxIN = 1'b1;
        steps(20);
        check("glitch_busy_seen", 32'(busy_seen), 32'h1);
        check("glitch_rises",     32'(rise_cnt), 32'd0);
        check("glitch_busy_end",  32'(busyOUT), 32'h0);
        check("glitch_data",      32'(dataOUT), 32'h3C);

        // 0xFF with a low stop bit, line held low afterwards
        clear_mon();
        send_frame(8'hFF, 1'b0, t0);
        steps(20);
        check("brk_ferr_pulses", 32'(ferr_cnt), 32'd1);
        check("brk_rises",       32'(rise_cnt), 32'd0);
        check("brk_data",        32'(dataOUT), 32'h3C);
        check("brk_busy_held",   32'(busyOUT), 32'h1);
        rxIN = 1'b1;
        steps(4);
        check("brk_busy_end",    32'(busyOUT), 32'h0);
        steps(4);

        // Overrun: 0x11 then 0x22 with no ack
        ack_auto = 1'b0;
        ackIN    = 1'b0;
        clear_mon();
        send_frame(8'h11, 1'b1, t0);
        steps(2);
        check("ovr_first_done", 32'(doneOUT), 32'h1);
        check("ovr_first_data", 32'(dataOUT), 32'h11);
        check("ovr_first_flag", 32'(overrunOUT), 32'h0);
        send_frame(8'h22, 1'b1, t0);
        steps(2);
        check("ovr_flag",  32'(overrunOUT), 32'h1);
        check("ovr_data",  32'(dataOUT), 32'h22);
        check("ovr_done",  32'(doneOUT), 32'h1);
        ackIN = 1'b1;
        step();
        ackIN = 1'b0;
        step();
        check("ovr_ack_done",    32'(doneOUT), 32'h0);
        check("ovr_ack_overrun", 32'(overrunOUT), 32'h0);

        // ackIN held high across a whole frame: the store must still win
        clear_mon();
        ackIN = 1'b1;
        send_frame(8'h5A, 1'b1, t0);
        steps(2);
        check("hold_ack_rises",   32'(rise_cnt), 32'd1);
        check("hold_ack_data",    32'(last_got), 32'h5A);
        check("hold_ack_overrun", 32'(overrunOUT), 32'h0);
        check("hold_ack_done",    32'(doneOUT), 32'h0);
        ackIN = 1'b0;
        steps(4);

        // Reset asserted in the middle of data bit 3 of 0x81
        clear_mon();
        rxIN = 1'b0;
        steps(CPB);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        rxIN = 1'b0;
        steps(4);
        check("mid_busy", 32'(busyOUT), 32'h1);
        #1 nResetIN = 1'b0;
        #1;
        check("arst_data",    32'(dataOUT),     32'h00);
        check("arst_done",    32'(doneOUT),     32'h0);
        check("arst_busy",    32'(busyOUT),     32'h0);
        check("arst_overrun", 32'(overrunOUT),  32'h0);
        check("arst_ferr",    32'(frameErrOUT), 32'h0);
        rxIN = 1'b1;
        steps(3);
        nResetIN = 1'b1;
        steps(4);
        ack_auto = 1'b1;
        clear_mon();
        send_frame(8'h81, 1'b1, t0);
        steps(4);
        check("post_rst_rises",   32'(rise_cnt), 32'd1);
        check("post_rst_data",    32'(last_got), 32'h81);
        check("post_rst_latency", 32'(rise_cyc - t0 - 1), 32'(LAT));
        check("post_rst_ferr",    32'(ferr_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
